mem_port_arbiter: RTL

//   Shares the multicycle CPU's single-ported unified memory between two requesters:

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Handshake: a requester raises req with we/addr/wdata and holds them until its
    // one-cycle ack; in the cycle after ack it drops req or presents the next request.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_ack, b_ack, rdata, busy,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_ack, b_ack, rdata, busy,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between requesters A and B,
// one transaction in flight, fixed MEM_LAT-cycle access, registered outputs.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_port_if.slave      bus,
    output logic [1:0]     state_dbg
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q;   // 0 = A, 1 = B
    logic              last_q;  // port granted most recently
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              grant, sel_b, sel_we, cnt_last;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              a_ack_d, b_ack_d, busy_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, rdata_d;

    assign grant     = (state_q == S_IDLE) && (bus.a_req || bus.b_req);
    // On a tie B wins only when A was served last.
    assign sel_b     = bus.b_req && (!bus.a_req || !last_q);
    assign sel_we    = sel_b ? bus.b_we    : bus.a_we;
    assign sel_addr  = sel_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = sel_b ? bus.b_wdata : bus.a_wdata;
    assign cnt_last  = (cnt_q == CNT_LAST);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            bus.a_ack     <= 1'b0;
            bus.b_ack     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rdata     <= '0;
        end else begin
            state_q       <= state_d;
            bus.a_ack     <= a_ack_d;
            bus.b_ack     <= b_ack_d;
            bus.busy      <= busy_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
            bus.rdata     <= rdata_d;
            if (grant) begin
                gnt_q  <= sel_b;
                last_q <= sel_b;
                we_q   <= sel_we;
                cnt_q  <= '0;
            end else if (state_q == S_ACCESS) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.a_req || bus.b_req) state_d = S_ACCESS;
            S_ACCESS: if (cnt_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; address and data only move on a grant.
    always_comb begin
        a_ack_d     = (state_q == S_ACCESS) && cnt_last && !gnt_q;
        b_ack_d     = (state_q == S_ACCESS) && cnt_last &&  gnt_q;
        busy_d      = (state_d != S_IDLE);
        mem_we_d    = grant && sel_we;
        mem_addr_d  = bus.mem_addr;
        mem_wdata_d = bus.mem_wdata;
        rdata_d     = bus.rdata;
        if (grant) begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
        end
        if ((state_q == S_ACCESS) && cnt_last && !we_q) begin
            rdata_d = bus.mem_rdata;
        end
    end
endmodule
